// File: rtl/target_lut_if.sv
// Bus bundle for target_lut: read/write requests, registered read data and status.
// TARGET_LUT_LOCK_EN adds the Lock input and WrReject output.
interface target_lut_if #(
   parameter int DW = 16,
   parameter int AW = 4
);
   logic          RdEn;
   logic [AW-1:0] RdAddr;
   logic          WrEn;
   logic [AW-1:0] WrAddr;
   logic [DW-1:0] WrData;
   logic [DW-1:0] Target;
   logic          TargetValid;
   logic          Busy;
   logic [0:0]    dbg_state;
`ifdef TARGET_LUT_LOCK_EN
   logic          Lock;
   logic          WrReject;
`endif

   modport master (
      output RdEn, RdAddr, WrEn, WrAddr, WrData,
      input  Target, TargetValid, Busy, dbg_state
`ifdef TARGET_LUT_LOCK_EN
      , output Lock
      , input  WrReject
`endif
   );

   modport slave (
      input  RdEn, RdAddr, WrEn, WrAddr, WrData,
      output Target, TargetValid, Busy, dbg_state
`ifdef TARGET_LUT_LOCK_EN
      , input  Lock
      , output WrReject
`endif
   );
endinterface

// File: rtl/target_lut.sv
// Target lookup table: self-initialises DEPTH entries after reset, then serves
// 1-cycle-latency reads with write-first bypass. Optional write lock: TARGET_LUT_LOCK_EN.
module target_lut #(
   parameter int DW = 16,
   parameter int AW = 4
) (
   input logic       Clk,
   input logic       Reset,
   target_lut_if.slave bus
);
   localparam int DEPTH = 1 << AW;

   localparam logic [0:0] S_INIT  = 1'b0;
   localparam logic [0:0] S_READY = 1'b1;

   logic [0:0]    state;
   logic [AW-1:0] initptr;
   logic [DW-1:0] mem [DEPTH];
   logic          ready;
   logic          rd_accept;
   logic          wr_accept;

   function automatic logic [DW-1:0] default_entry(input logic [AW-1:0] idx);
      int v;
      case (int'(idx))
         1:       v = 1;
         2:       v = 4;
         3:       v = 61;
         4:       v = 62;
         5:       v = 63;
         6:       v = 32;
         7:       v = 64;
         8:       v = 255;
         default: v = 0;
      endcase
      return DW'(v);
   endfunction

   assign ready         = (state == S_READY);
   assign bus.Busy      = (state == S_INIT);
   assign bus.dbg_state = state;
   assign rd_accept     = ready && bus.RdEn;

`ifdef TARGET_LUT_LOCK_EN
   logic locked;
   // The flag is checked before it is set, so the write coinciding with the
   // first Lock still lands.
   assign wr_accept = ready && bus.WrEn && !locked;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         locked       <= 1'b0;
         bus.WrReject <= 1'b0;
      end else begin
         bus.WrReject <= ready && bus.WrEn && locked;
         if (ready && bus.Lock) locked <= 1'b1;
      end
   end
`else
   assign wr_accept = ready && bus.WrEn;
`endif

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= S_INIT;
         initptr <= '0;
      end else if (state == S_INIT) begin
         initptr <= initptr + 1'b1;
         if (&initptr) state <= S_READY;
      end
   end

   // The table itself needs no reset: INIT rewrites every entry.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         if (state == S_INIT) mem[initptr] <= default_entry(initptr);
         else if (wr_accept)  mem[bus.WrAddr] <= bus.WrData;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         bus.Target      <= '0;
         bus.TargetValid <= 1'b0;
      end else begin
         bus.TargetValid <= rd_accept;
         if (rd_accept) begin
            if (wr_accept && (bus.WrAddr == bus.RdAddr)) bus.Target <= bus.WrData;
            else                                         bus.Target <= mem[bus.RdAddr];
         end
      end
   end
endmodule

// File: tb/tb_target_lut.sv
// Randomised self-checking bench for target_lut against a table-level reference model.
// Lock scenarios are exercised when TARGET_LUT_LOCK_EN is defined.
module tb_target_lut;
   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic Clk = 1'b0;
   logic Reset;
   logic lock_req;

   target_lut_if #(.DW(DW), .AW(AW)) bus ();

   target_lut #(.DW(DW), .AW(AW)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

`ifdef TARGET_LUT_LOCK_EN
   assign bus.Lock = lock_req;
`endif

   // clock / reset
   always #5 Clk = ~Clk;

   // reference model state
   logic [DW-1:0] table_m [DEPTH];
   int            init_left;
   logic          exp_valid;
   logic          exp_reject;
   logic          locked_m;
   logic [DW-1:0] exp_q [$];
   int            n_checks;
   int            n_pass;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic void load_defaults();
      int dflt [9] = '{0, 1, 4, 61, 62, 63, 32, 64, 255};
      for (int i = 0; i < DEPTH; i++)
         table_m[i] = (i < 9) ? DW'(dflt[i]) : '0;
   endfunction

   // driver: apply one cycle of inputs, advance the model, check outputs #1 after the edge
   task automatic cycle(input logic rst, input logic rd, input logic [AW-1:0] ra,
                        input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic lk);
      logic [DW-1:0] e;
      Reset = rst; bus.RdEn = rd; bus.RdAddr = ra;
      bus.WrEn = wr; bus.WrAddr = wa; bus.WrData = wd; lock_req = lk;
      @(posedge Clk);
      exp_reject = 1'b0;
      if (rst) begin
         init_left = DEPTH;
         exp_valid = 1'b0;
         locked_m  = 1'b0;
         load_defaults();
      end else if (init_left > 0) begin
         init_left--;
         exp_valid = 1'b0;
      end else begin
         exp_valid = rd;
         if (rd) begin
            e = (wr && !locked_m && wa == ra) ? wd : table_m[ra];
            exp_q.push_back(e);
         end
         if (wr) begin
            if (locked_m) exp_reject = 1'b1;
            else table_m[wa] = wd;
         end
`ifdef TARGET_LUT_LOCK_EN
         if (lk) locked_m = 1'b1;
`endif
      end
      #1;
      check("busy", bus.Busy, init_left > 0);
      check("target_valid", bus.TargetValid, exp_valid);
      if (bus.TargetValid && exp_q.size() > 0) check("target", bus.Target, exp_q.pop_front());
`ifdef TARGET_LUT_LOCK_EN
      check("wr_reject", bus.WrReject, exp_reject);
`endif
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      cycle(1'b0, 1'b1, a, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic run_to_ready();
      int guard = 0;
      while (bus.Busy && guard < 4 * DEPTH) begin
         idle();
         guard++;
      end
      check("ready_reached", bus.Busy, 1'b0);
   endtask

   initial begin
      int busy_cycles;
      n_checks = 0; n_pass = 0;
      init_left = DEPTH; locked_m = 1'b0; exp_valid = 1'b0; exp_reject = 1'b0;
      load_defaults();

      // reset state
      do_reset();
      check("reset_target", bus.Target, '0);

      // busy window length, with reads issued during it being dropped
      busy_cycles = 1;
      for (int i = 0; i < 4 * DEPTH && bus.Busy; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), AW'($urandom), 1'b0, '0, '0, 1'b0);
         if (bus.Busy) busy_cycles++;
      end
      check("busy_len", busy_cycles, DEPTH);

      // back-to-back readout of the default table
      for (int a = 0; a < DEPTH; a++) rd(AW'(a));
      idle();

      // same-cycle write/read bypass, then plain read
      cycle(1'b0, 1'b1, AW'(5), 1'b1, AW'(5), DW'(16'h1234), 1'b0);
      idle();
      rd(AW'(5));
      check("addr5_persist", bus.Target, DW'(16'h1234));

      // write, reset, re-reset mid-INIT: prior write must be gone
      cycle(1'b0, 1'b0, '0, 1'b1, AW'(9), DW'(16'hABCD), 1'b0);
      do_reset();
      for (int i = 0; i < 7; i++) idle();
      do_reset();
      run_to_ready();
      rd(AW'(9));
      check("addr9_cleared", bus.Target, '0);
      rd(AW'(8));
      check("addr8_default", bus.Target, DW'(255));

`ifdef TARGET_LUT_LOCK_EN
      // lock, rejected write, reset clears lock
      cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
      cycle(1'b0, 1'b0, '0, 1'b1, AW'(2), DW'(16'h00FF), 1'b0);
      idle();
      rd(AW'(2));
      check("addr2_locked", bus.Target, DW'(4));
      do_reset();
      run_to_ready();
      cycle(1'b0, 1'b0, '0, 1'b1, AW'(2), DW'(16'h00FF), 1'b1);
      cycle(1'b0, 1'b1, AW'(2), 1'b1, AW'(2), DW'(16'h5555), 1'b0);
      check("addr2_first_lock_write", bus.Target, DW'(16'h00FF));
`endif

      // random traffic with occasional resets, narrow address range to provoke collisions
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)),
               1'($urandom_range(0, 1)), AW'($urandom_range(0, 5)), DW'($urandom),
               ($urandom_range(0, 99) == 0));
      end
      idle();
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/target_lut.md
TARGET_LUT -- requirements
Module: target_lut

Interface
REQ-001 Parameter DW, default 16, Target/data width in bits.
REQ-002 Parameter AW, default 4, address width; DEPTH = 2**AW entries.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 RdEn  input  1  read request, sampled on Clk.
REQ-006 RdAddr  input  AW  read index.
REQ-007 WrEn  input  1  write request, sampled on Clk.
REQ-008 WrAddr  input  AW  write index.
REQ-009 WrData  input  DW  write value.
REQ-010 Target  output  DW  registered read data.
REQ-011 TargetValid  output  1  Target holds data for the read accepted on the previous cycle.
REQ-012 Busy  output  1  table initialising; reads and writes are not accepted.

Function
REQ-013 Two states: INIT and READY; Busy = (state == INIT).
REQ-014 INIT writes one entry per cycle at index initptr (0..DEPTH-1), then moves to READY on the cycle after writing DEPTH-1; duration is exactly DEPTH cycles.
REQ-015 Default table: idx0=0, 1=1, 2=4, 3=61, 4=62, 5=63, 6=32, 7=64, 8=255; every other index = 0; values zero-extended or truncated to DW.
REQ-016 In READY, RdEn=1 is accepted: Target <= entry[RdAddr] and TargetValid <= 1 on the next edge (1-cycle latency).
REQ-017 Cycle with RdEn=0 or state INIT: TargetValid <= 0; Target holds its last value.
REQ-018 In READY, WrEn=1 writes WrData to entry[WrAddr] at the edge.
REQ-019 Same-cycle read and write to the same address return WrData (write-first bypass); different addresses are independent.
REQ-020 RdEn/WrEn asserted while Busy are dropped silently, not queued.
REQ-021 Back-to-back reads on consecutive cycles are fully pipelined, one result per cycle.

Reset
REQ-022 Reset=1 forces state INIT, initptr 0, Target 0, TargetValid 0, Busy 1 on the next edge.
REQ-023 Reset asserted mid-INIT or mid-operation restarts INIT from index 0; all prior writes are lost once INIT completes.
REQ-024 Reset has priority over RdEn and WrEn in the same cycle.

Configuration
REQ-025 Macro TARGET_LUT_LOCK_EN, when defined, adds port Lock (input, 1) and port WrReject (output, 1, registered, reset 0).
REQ-026 With TARGET_LUT_LOCK_EN: Lock=1 in READY sets a sticky locked flag, which is cleared only by Reset; while the flag is set, writes are ignored and WrReject pulses high for one cycle per rejected WrEn.
REQ-027 With TARGET_LUT_LOCK_EN: a write in the same cycle as the first Lock=1 is still performed.
REQ-028 Without TARGET_LUT_LOCK_EN: no Lock or WrReject ports; writes are always accepted in READY.

Verification
REQ-029 Reset 1 cycle, then idle -> Busy=1 for exactly 16 cycles, then 0; RdEn during Busy gives TargetValid=0.
REQ-030 After init, read addrs 0..15 back-to-back -> Target = 0,1,4,61,62,63,32,64,255,0..0, one per cycle, TargetValid=1 throughout.
REQ-031 Write addr 5 = 16'h1234 with same-cycle read addr 5 -> next cycle Target=16'h1234; later read addr 5 -> 16'h1234.
REQ-032 Write addr 9 = 16'hABCD, assert Reset mid-INIT at cycle 7, run to READY -> read addr 9 returns 0, addr 8 returns 255.
REQ-033 With TARGET_LUT_LOCK_EN: Lock=1, then write addr 2 = 16'h00FF -> WrReject=1 for 1 cycle, read addr 2 returns 4; Reset clears the lock.
REQ-034 Parameter sweep DW=8, AW=3 -> INIT lasts 8 cycles, idx7=64, 255 truncated out of range (idx8 absent), 61 reads as 8'd61.
